fpu_req_sequencer: RTL and testbench
====================================

// Module: fpu_req_sequencer
// PURPOSE
//  Initiator side of the FPU operand interface: accepts add/sub requests from the host over valid/ready.
//  Drives a/b plus a one-cycle data_valid pulse into fp_subtract.
//  Waits the unit's fixed result latency, captures diff/error, and returns tagged results over valid/ready.
//  ADD is issued as a - (-b) by flipping b[31] before issue. Sits between the host command path and the FPU core.
// PARAMETERS
//  RESULT_LAT  4   cycles from the data_valid cycle (cycle 0) to the cycle fpu_diff_i/fpu_error_i are sampled
//  TAG_W       4   width of the request/response tag
//  CNT_W       16  width of the saturating error counter
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-high reset
//  req_valid_i   in   1       host request valid
//  req_ready_o   out  1       sequencer can accept a request (IDLE only)
//  req_a_i       in   32      IEEE-754 operand A
//  req_b_i       in   32      IEEE-754 operand B
//  req_op_i      in   1       0 = SUB (a-b), 1 = ADD (a+b)
//  req_tag_i     in   TAG_W   opaque tag, echoed on the response
//  fpu_valid_o   out  1       data_valid to FPU; exactly one cycle per request
//  fpu_a_o       out  32      operand A to FPU; held stable from issue to capture
//  fpu_b_o       out  32      operand B to FPU (sign flipped for ADD); held stable from issue to capture
//  fpu_diff_i    in   32      FPU result
//  fpu_error_i   in   1       FPU invalid-operand flag
//  rsp_valid_o   out  1       response valid
//  rsp_ready_i   in   1       host accepts the response
//  rsp_result_o  out  32      captured result
//  rsp_error_o   out  1       captured error flag
//  rsp_tag_o     out  TAG_W   tag of the request
//  busy_o        out  1       high in any state except IDLE
//  err_cnt_o     out  CNT_W   saturating count of responses with rsp_error_o = 1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0. req_ready_o is 0 during the reset cycle and 1 on the first cycle after.
//  States:
//   IDLE: req_ready_o = 1. On req_valid_i, register a, b' and tag, then go to ISSUE.
//    - b' = {req_b_i[31] ^ req_op_i, req_b_i[30:0]}.
//   ISSUE: fpu_valid_o = 1 for this cycle only. Load lat_cnt = 1, then go to WAIT.
//   WAIT: lat_cnt increments each cycle. When lat_cnt == RESULT_LAT, sample fpu_diff_i/fpu_error_i into the response registers, then go to RESP.
//   RESP: rsp_valid_o = 1. rsp_result_o, rsp_error_o and rsp_tag_o are stable until the handshake.
//    - On rsp_valid_o & rsp_ready_i, go to IDLE. If rsp_error_o, increment err_cnt_o, saturating at all-ones.
//  Handshake rules:
//   - A request is accepted only when req_valid_i & req_ready_o. Requests presented outside IDLE are not sampled.
//   - No combinational path from rsp_ready_i to req_ready_o. A new request is accepted no earlier than the cycle after the response handshake.
//  Timing:
//   - Minimum request-to-response latency: 1 accept + 1 issue + RESULT_LAT wait = RESULT_LAT+2 cycles to rsp_valid_o.
//   - Best-case throughput: one request every RESULT_LAT+3 cycles.
//   - lat_cnt is $clog2(RESULT_LAT+1) bits wide and never wraps; it compares equal before overflow.
//   - RESULT_LAT must be >= 1; enforce with an elaboration-time assertion.
//  Operands: fpu_a_o/fpu_b_o hold their values from ISSUE through the capture cycle and keep them afterwards, with no toggle until the next accept.
//  Reset mid-operation: synchronous rst in any state returns to IDLE the next cycle.
//   - Any pending response is discarded; err_cnt_o clears; fpu_valid_o is 0.
//   - The FPU is reset on the same rst, so no stale result can appear.
//  Backpressure: rsp_ready_i held low leaves the block in RESP indefinitely, with outputs stable and req_ready_o = 0.
// STRUCTURE
//  fpu_pkg (shared):
//   - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;
//   - typedef enum logic {FP_SUB = 1'b0, FP_ADD = 1'b1} fp_op_t;
//   - localparam FP_QNAN = 32'h7fffffff; localparam FP_SIGN_BIT = 31.
//  Single module; no sub-module. The saturating counter is inline (~5 lines).
// TESTING
//  1. SUB 3.0-1.0: a=32'h40400000, b=32'h3F800000, op=0 -> fpu_b_o=32'h3F800000; rsp_result_o=32'h40000000, rsp_error_o=0.
//  2. ADD 1.0+1.0: a=b=32'h3F800000, op=1 -> fpu_b_o=32'hBF800000; rsp_result_o=32'h40000000; tag echoed.
//  3. NaN operand: a=32'h7FC00000, b=32'h3F800000 -> rsp_error_o=1, rsp_result_o=32'h7FFFFFFF, err_cnt_o 0->1.
//  4. Backpressure: hold rsp_ready_i=0 for 10 cycles after rsp_valid_o -> outputs stable, req_ready_o=0, fpu_valid_o never re-pulses.
//  5. Timing: req_valid_i held high with distinct tags 1,2,3 -> fpu_valid_o is a 1-cycle pulse per request; responses in tag order.
//     - rsp_valid_o rises exactly RESULT_LAT+2 cycles after each accept.
//  6. Reset in WAIT: assert rst for 1 cycle at lat_cnt=2 -> next cycle IDLE, rsp_valid_o=0, err_cnt_o=0, and no response emitted.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request path.
// Used by the sequencer and by anything that talks to fp_subtract.
package fpu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;

  typedef enum logic {FP_SUB = 1'b0, FP_ADD = 1'b1} fp_op_t;

  localparam logic [31:0] FP_QNAN     = 32'h7fffffff;
  localparam int          FP_SIGN_BIT = 31;

endpackage

// File: rtl/fpu_req_sequencer.sv
// Host-side sequencer for fp_subtract: takes one add/sub request at a time,
// issues it, waits the fixed FPU latency and returns a tagged response.
module fpu_req_sequencer
  import fpu_pkg::*;
#(
  parameter int RESULT_LAT = 4,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic             req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             fpu_valid_o,
  output logic [31:0]      fpu_a_o,
  output logic [31:0]      fpu_b_o,
  input  logic [31:0]      fpu_diff_i,
  input  logic             fpu_error_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_error_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int LAT_W = $clog2(RESULT_LAT + 1);

  if (RESULT_LAT < 1) begin : gLatCheck
    $error("fpu_req_sequencer: RESULT_LAT must be >= 1");
  end

  seq_state_t       state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [31:0]      res_q, res_d;
  logic             errf_q, errf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      lat_q   <= '0;
      res_q   <= '0;
      errf_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      lat_q   <= lat_d;
      res_q   <= res_d;
      errf_q  <= errf_d;
      cnt_q   <= cnt_d;
    end
  end

  // ADD is turned into a - (-b) by flipping the sign of b at accept time.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    lat_d   = lat_q;
    res_d   = res_q;
    errf_d  = errf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          a_d     = req_a_i;
          b_d     = {req_b_i[FP_SIGN_BIT] ^ (fp_op_t'(req_op_i) == FP_ADD),
                     req_b_i[FP_SIGN_BIT-1:0]};
          tag_d   = req_tag_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_W'(RESULT_LAT)) begin
          res_d   = fpu_diff_i;
          errf_d  = fpu_error_i;
          state_d = RESP;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          if (errf_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Ready is gated by rst so it reads 0 throughout the reset cycle.
  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign fpu_valid_o  = (state_q == ISSUE);
  assign rsp_valid_o  = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign fpu_a_o      = a_q;
  assign fpu_b_o      = b_q;
  assign rsp_result_o = res_q;
  assign rsp_error_o  = errf_q;
  assign rsp_tag_o    = tag_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Bench for fpu_req_sequencer: a behavioural fp_subtract stand-in plus a
// request-level reference model built on real arithmetic.
module tb_fpu_req_sequencer;
  import fpu_pkg::*;

  localparam int RESULT_LAT = 4;
  localparam int TAG_W      = 4;
  localparam int CNT_W      = 16;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready_o;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_op;
  logic [TAG_W-1:0] req_tag;
  logic             fpu_valid_o;
  logic [31:0]      fpu_a_o;
  logic [31:0]      fpu_b_o;
  logic [31:0]      fpu_diff_i;
  logic             fpu_error_i;
  logic             rsp_valid_o;
  logic             rsp_ready;
  logic [31:0]      rsp_result_o;
  logic             rsp_error_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             busy_o;
  logic [CNT_W-1:0] err_cnt_o;

  fpu_req_sequencer #(
    .RESULT_LAT(RESULT_LAT),
    .TAG_W     (TAG_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .req_tag_i   (req_tag),
    .fpu_valid_o (fpu_valid_o),
    .fpu_a_o     (fpu_a_o),
    .fpu_b_o     (fpu_b_o),
    .fpu_diff_i  (fpu_diff_i),
    .fpu_error_i (fpu_error_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result_o),
    .rsp_error_o (rsp_error_o),
    .rsp_tag_o   (rsp_tag_o),
    .busy_o      (busy_o),
    .err_cnt_o   (err_cnt_o)
  );

  int          testsRun    = 0;
  int          testsFailed = 0;
  int unsigned cyc         = 0;
  int          pulseCount  = 0;
  int          fpuCnt      = -1;
  int          modelErrCnt = 0;
  int          lastAcceptCyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit isNan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real sp2real(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'd0, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural fp_subtract: a - b, NaN operands give the quiet NaN and error.
  function automatic logic [32:0] fpuModel(input logic [31:0] a, input logic [31:0] b);
    if (isNan(a) || isNan(b)) return {1'b1, FP_QNAN};
    return {1'b0, real2sp(sp2real(a) - sp2real(b))};
  endfunction

  // What the host should get back for a request, computed from its op directly.
  function automatic logic [32:0] refResult(input logic [31:0] a, input logic [31:0] b, input logic op);
    real ra, rb;
    if (isNan(a) || isNan(b)) return {1'b1, FP_QNAN};
    ra = sp2real(a);
    rb = sp2real(b);
    return {1'b0, real2sp(op ? (ra + rb) : (ra - rb))};
  endfunction

  function automatic logic [31:0] randFloat();
    int v;
    v = int'($urandom_range(0, 100)) - 50;
    return real2sp(real'(v));
  endfunction

  // FPU stand-in: correct result only in the exact capture cycle, noise otherwise.
  initial begin
    fpu_diff_i  = 32'd0;
    fpu_error_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) fpuCnt = -1;
      else if (fpu_valid_o) fpuCnt = 0;
      else if (fpuCnt >= 0) fpuCnt++;
      if (fpu_valid_o && !rst) pulseCount++;
      if (fpuCnt == RESULT_LAT) begin
        {fpu_error_i, fpu_diff_i} = fpuModel(fpu_a_o, fpu_b_o);
      end else begin
        fpu_diff_i  = $urandom;
        fpu_error_i = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                               input logic [TAG_W-1:0] tag, input int holdCycles,
                               input bit keepValid);
    logic [32:0] exp;
    logic [31:0] expB;
    int          startPulses;
    int          waitCnt;
    exp  = refResult(a, b, op);
    expB = op ? {~b[31], b[30:0]} : b;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    waitCnt   = 0;
    while (!req_ready_o && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready_o) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    lastAcceptCyc = int'(cyc);
    startPulses   = pulseCount;
    @(negedge clk);
    if (keepValid) begin
      req_a   = $urandom;
      req_b   = $urandom;
      req_op  = 1'($urandom_range(0, 1));
      req_tag = TAG_W'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    waitCnt = 0;
    while (!rsp_valid_o && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rsp_valid_o) begin
      checkOutput("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    checkOutput("latency", 64'(int'(cyc) - lastAcceptCyc), 64'(RESULT_LAT + 2));
    checkOutput("fpu_a", 64'(fpu_a_o), 64'(a));
    checkOutput("fpu_b", 64'(fpu_b_o), 64'(expB));
    checkOutput("rsp_result", 64'(rsp_result_o), 64'(exp[31:0]));
    checkOutput("rsp_error", 64'(rsp_error_o), 64'(exp[32]));
    checkOutput("rsp_tag", 64'(rsp_tag_o), 64'(tag));
    checkOutput("fpu_pulses", 64'(pulseCount - startPulses), 64'd1);
    checkOutput("busy", 64'(busy_o), 64'd1);
    checkOutput("req_ready_in_resp", 64'(req_ready_o), 64'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 64'(rsp_valid_o), 64'd1);
      checkOutput("hold_result", 64'(rsp_result_o), 64'(exp[31:0]));
      checkOutput("hold_tag", 64'(rsp_tag_o), 64'(tag));
      checkOutput("hold_ready", 64'(req_ready_o), 64'd0);
      checkOutput("hold_fpu_b", 64'(fpu_b_o), 64'(expB));
      checkOutput("hold_pulses", 64'(pulseCount - startPulses), 64'd1);
    end
    rsp_ready = 1'b1;
    if (exp[32] && modelErrCnt < (1 << CNT_W) - 1) modelErrCnt++;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("err_cnt", 64'(err_cnt_o), 64'(modelErrCnt));
    checkOutput("rsp_valid_drop", 64'(rsp_valid_o), 64'd0);
    checkOutput("ready_after_rsp", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    int prevAccept;
    int rspSeen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    req_op    = 1'b0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready_o), 64'd0);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_fpu_valid", 64'(fpu_valid_o), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("reset_err_cnt", 64'(err_cnt_o), 64'd0);
    checkOutput("reset_fpu_a", 64'(fpu_a_o), 64'd0);
    checkOutput("reset_rsp_result", 64'(rsp_result_o), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", 64'(req_ready_o), 64'd1);
    @(negedge clk);

    $display("[TB] directed: sub, add, NaN, backpressure");
    applyStimulus(32'h40400000, 32'h3F800000, 1'b0, 4'h1, 0, 1'b0);
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 4'hA, 1, 1'b0);
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0, 4'h3, 0, 1'b0);
    applyStimulus(32'h40A00000, 32'hC0000000, 1'b1, 4'h5, 10, 1'b0);

    $display("[TB] back-to-back with req_valid held high");
    applyStimulus(randFloat(), randFloat(), 1'b0, 4'h1, 0, 1'b1);
    prevAccept = lastAcceptCyc;
    applyStimulus(randFloat(), randFloat(), 1'b1, 4'h2, 0, 1'b1);
    checkOutput("throughput_2", 64'(lastAcceptCyc - prevAccept), 64'(RESULT_LAT + 3));
    prevAccept = lastAcceptCyc;
    applyStimulus(randFloat(), randFloat(), 1'b0, 4'h3, 0, 1'b0);
    checkOutput("throughput_3", 64'(lastAcceptCyc - prevAccept), 64'(RESULT_LAT + 3));

    $display("[TB] randomized transactions");
    for (int n = 0; n < 16; n++) begin
      logic [31:0] ra, rb;
      ra = randFloat();
      rb = randFloat();
      if ($urandom_range(0, 7) == 0) ra = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 1000))};
      if ($urandom_range(0, 7) == 0) rb = 32'h7FC00001;
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), TAG_W'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      req_valid = 1'b0;
    end

    $display("[TB] reset while waiting on the FPU");
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b1, 4'h7, 0, 1'b0);
    req_valid = 1'b1;
    req_a     = 32'h7FC00000;
    req_b     = 32'h3F800000;
    req_op    = 1'b0;
    req_tag   = 4'h9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset_req_ready", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    modelErrCnt = 0;
    #1;
    checkOutput("midreset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("midreset_busy", 64'(busy_o), 64'd0);
    checkOutput("midreset_err_cnt", 64'(err_cnt_o), 64'd0);
    checkOutput("midreset_fpu_valid", 64'(fpu_valid_o), 64'd0);
    checkOutput("midreset_ready", 64'(req_ready_o), 64'd1);
    rspSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o || busy_o) rspSeen++;
    end
    checkOutput("midreset_no_rsp", 64'(rspSeen), 64'd0);
    applyStimulus(32'h40400000, 32'h3F800000, 1'b0, 4'hC, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
